iir_tdm_sched: RTL and testbench

//  Scheduler for the shared, time-multiplexed biquad datapath of the multi-channel IIR filter.

---
 rtl/iir_tdm_sched.sv | 160 ++++++++++++++++
 tb/tb_iir_tdm_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_tdm_sched.sv
// Round-robin scheduler for the shared time-multiplexed biquad MAC.
// Sequences STAGES passes per sample and returns a rounded, saturated result.
`timescale 1ns/1ps
module iir_tdm_sched #(
  parameter int NCH      = 3,
  parameter int STAGES   = 2,
  parameter int PIPE_LAT = 4,
  parameter int ACC_W    = 36,
  parameter int OUT_W    = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  output logic             dp_start,
  output logic [1:0]       dp_ch,
  output logic [1:0]       dp_sec,
  output logic             dp_fb_sel,
  input  logic [ACC_W-1:0] dp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_ch,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
);

  localparam int WW = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;
  localparam int HW = ACC_W - OUT_W - 23;
  localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [1:0] LAST = 2'(STAGES - 1);

  typedef enum logic [2:0] {
    IDLE, GRANT, ISSUE, WAIT, OUT
  } state_t;

  state_t        state;
  logic [1:0]    rr_ptr;
  logic [1:0]    w;
  logic [1:0]    sec;
  logic [WW-1:0] wcnt;
  logic [1:0]    nxt;
  logic [1:0]    win_idle;
  logic [1:0]    win_out;

  function automatic logic [1:0] pick(
    input logic [NCH-1:0] v,
    input logic [1:0]     p
  );
    logic [1:0] r;
    int         j;
    r = p;
    for (int i = NCH - 1; i >= 0; i--) begin
      j = (int'(p) + i) % NCH;
      if (v[j]) r = 2'(j);
    end
    return r;
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [1:0] idx);
    logic [NCH-1:0] g;
    g = '0;
    g[idx] = 1'b1;
    return g;
  endfunction

  // Q.24 -> integer: round half up, clamp to the signed OUT_W range.
  function automatic logic [OUT_W-1:0] rnd(input logic [ACC_W-1:0] a);
    logic             s;
    logic [OUT_W-1:0] ip;
    s  = a[ACC_W-1];
    ip = a[OUT_W+23:24];
    if (a[ACC_W-1:OUT_W+23] != {HW{s}}) begin
      return s ? MINV : MAXV;
    end else if (ip == MAXV && a[23]) begin
      return MAXV;
    end else begin
      return ip + OUT_W'(a[23]);
    end
  endfunction

  assign nxt      = (w == 2'(NCH - 1)) ? 2'd0 : w + 2'd1;
  assign win_idle = pick(in_valid, rr_ptr);
  assign win_out  = pick(in_valid, nxt);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      w         <= '0;
      sec       <= '0;
      wcnt      <= '0;
      in_ready  <= '0;
      dp_start  <= 1'b0;
      dp_ch     <= '0;
      dp_sec    <= '0;
      dp_fb_sel <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else begin
      in_ready <= '0;
      dp_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|in_valid) begin
            w        <= win_idle;
            in_ready <= onehot(win_idle);
            state    <= GRANT;
          end
        end
        GRANT: begin
          sec       <= '0;
          dp_start  <= 1'b1;
          dp_ch     <= w;
          dp_sec    <= '0;
          dp_fb_sel <= 1'b0;
          state     <= ISSUE;
        end
        ISSUE: begin
          wcnt  <= WW'(PIPE_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - 1'b1;
          end else if (sec == LAST) begin
            out_valid <= 1'b1;
            out_ch    <= w;
            out_data  <= rnd(dp_result);
            state     <= OUT;
          end else begin
            sec       <= sec + 2'd1;
            dp_start  <= 1'b1;
            dp_sec    <= sec + 2'd1;
            dp_fb_sel <= 1'b1;
            state     <= ISSUE;
          end
        end
        OUT: begin
          // Re-arbitrate on accept so back-to-back samples lose no cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            rr_ptr    <= nxt;
            if (|in_valid) begin
              w        <= win_out;
              in_ready <= onehot(win_out);
              state    <= GRANT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_tdm_sched.sv
// Directed bench for iir_tdm_sched: scoreboard of expected outputs,
// cycle-accurate checks on grants, datapath issue and output hold.
`timescale 1ns/1ps
module tb_iir_tdm_sched;

  localparam int NCH      = 3;
  localparam int STAGES   = 2;
  localparam int PIPE_LAT = 4;
  localparam int ACC_W    = 36;
  localparam int OUT_W    = 11;
  localparam int PASS_T   = PIPE_LAT + 1;
  localparam int LAT      = 1 + STAGES * PASS_T;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic             dp_start;
  logic [1:0]       dp_ch;
  logic [1:0]       dp_sec;
  logic             dp_fb_sel;
  logic [ACC_W-1:0] dp_result;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_ch;
  logic [OUT_W-1:0] out_data;
  logic             busy;

  iir_tdm_sched #(
    .NCH(NCH), .STAGES(STAGES), .PIPE_LAT(PIPE_LAT),
    .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .dp_start(dp_start), .dp_ch(dp_ch), .dp_sec(dp_sec),
    .dp_fb_sel(dp_fb_sel), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic rst_q = 1'b0;

  logic [12:0] sb [$];
  int gch [$];
  int gcyc [$];
  int grant_cyc = 0;
  int cur_ch = 0;
  int pass = 0;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [1:0] pch = '0;
  logic [OUT_W-1:0] pdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: floor(x / 2^24) + bit23, clamped to 11-bit signed.
  function automatic logic [OUT_W-1:0] model(input logic [ACC_W-1:0] r);
    longint s;
    longint q;
    s = $signed(r);
    q = (s >>> 24) + longint'(r[23]);
    if (q > 1023) q = 1023;
    if (q < -1024) q = -1024;
    return q[OUT_W-1:0];
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  always @(negedge clk) begin
    logic [12:0] e;
    int ch;
    if (!rst_q) begin
      chk("rst_in_ready", 64'(in_ready), 0);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_dp_start", 64'(dp_start), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_dp_sel", 64'({dp_ch, dp_sec, dp_fb_sel}), 0);
      chk("rst_out_bus", 64'({out_ch, out_data}), 0);
      sb.delete();
      pass = 0;
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (in_ready != '0) begin
        chk("grant_onehot", 64'($onehot(in_ready)), 1);
        chk("grant_handshake", 64'(|(in_ready & in_valid)), 1);
        ch = 0;
        for (int i = 0; i < NCH; i++) if (in_ready[i]) ch = i;
        sb.push_back({2'(ch), model(dp_result)});
        gch.push_back(ch);
        gcyc.push_back(cyc);
        grant_cyc = cyc;
        cur_ch = ch;
        pass = 0;
      end
      if (dp_start) begin
        chk("dp_ch", 64'(dp_ch), 64'(cur_ch));
        chk("dp_sec", 64'(dp_sec), 64'(pass));
        chk("dp_fb_sel", 64'(dp_fb_sel), 64'(pass != 0));
        chk("dp_start_cyc", 64'(cyc), 64'(grant_cyc + 1 + pass * PASS_T));
        pass++;
      end
      if (out_valid) begin
        chk("in_ready_in_out", 64'(in_ready), 0);
        if (!pv) begin
          chk("out_latency", 64'(cyc), 64'(grant_cyc + LAT));
        end else if (!pr) begin
          chk("hold_ch", 64'(out_ch), 64'(pch));
          chk("hold_data", 64'(out_data), 64'(pdata));
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            chk("out_unexpected", 64'(out_valid), 0);
          end else begin
            e = sb.pop_front();
            chk("out_ch", 64'(out_ch), 64'(e[12:11]));
            chk("out_data", 64'(out_data), 64'(e[10:0]));
          end
        end
      end
      pv = out_valid;
      pr = out_ready;
      pch = out_ch;
      pdata = out_data;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [NCH-1:0] m);
    int k;
    k = 0;
    in_valid = in_valid | m;
    while ((in_ready & m) == '0 && k < 60) begin
      step(1);
      k++;
    end
    chk("send_grant", 64'(in_ready & m), 64'(m));
    step(1);
    in_valid = in_valid & ~m;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < budget) begin
      step(1);
      k++;
    end
    chk("idle_busy", 64'(busy), 0);
    chk("idle_drain", 64'(sb.size()), 0);
  endtask

  logic [ACC_W-1:0] vec [8];

  initial begin
    int k;
    vec[0] = 36'h0_0180_0000;
    vec[1] = 36'h7_FF40_0000;
    vec[2] = 36'h1_0000_0000;
    vec[3] = 36'h8_0000_0000;
    vec[4] = 36'h4_0000_0000;
    vec[5] = 36'h3_FF80_0000;
    vec[6] = 36'hF_FF80_0000;
    vec[7] = 36'h7_FFFF_FFFF;

    reset = 1'b0;
    in_valid = 3'b111;
    out_ready = 1'b1;
    dp_result = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("t1_in_ready", 64'(in_ready), 0);
    chk("t1_busy", 64'(busy), 0);
    chk("t1_out_valid", 64'(out_valid), 0);

    reset = 1'b1;
    in_valid = '0;
    step(2);

    dp_result = 36'h0_0180_0000;
    send(3'b010);
    wait_idle(40);
    chk("t2_passes", 64'(pass), 64'(STAGES));

    reset = 1'b0;
    step(2);
    reset = 1'b1;
    gch.delete();
    gcyc.delete();
    dp_result = 36'h7_FF40_0000;
    in_valid = 3'b111;
    k = 0;
    while (gch.size() < 4 && k < 100) begin
      step(1);
      k++;
    end
    in_valid = '0;
    chk("t3_grants", 64'(gch.size() >= 4), 1);
    if (gch.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t3_rr_order", 64'(gch[i]), 64'(i % NCH));
      end
      for (int i = 1; i < 4; i++) begin
        chk("t3_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(2 + STAGES * PASS_T));
      end
    end
    wait_idle(60);

    for (int i = 0; i < 8; i++) begin
      dp_result = vec[i];
      send(3'b001);
      wait_idle(40);
    end

    dp_result = 36'h0_0280_0000;
    out_ready = 1'b0;
    send(3'b001);
    in_valid = 3'b110;
    k = 0;
    while (!out_valid && k < 40) begin
      step(1);
      k++;
    end
    chk("t5_out_valid", 64'(out_valid), 1);
    step(20);
    chk("t5_still_valid", 64'(out_valid), 1);
    chk("t5_data", 64'(out_data), 64'(model(36'h0_0280_0000)));
    in_valid = '0;
    out_ready = 1'b1;
    step(1);
    chk("t5_idle_busy", 64'(busy), 0);
    chk("t5_idle_valid", 64'(out_valid), 0);
    wait_idle(10);

    dp_result = 36'h0_0500_0000;
    send(3'b100);
    k = 0;
    while (pass < 2 && k < 30) begin
      step(1);
      k++;
    end
    chk("t6_second_pass", 64'(pass), 2);
    step(1);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("t6_busy", 64'(busy), 0);
    chk("t6_out_valid", 64'(out_valid), 0);
    in_valid = 3'b111;
    k = 0;
    while (in_ready == '0 && k < 10) begin
      step(1);
      k++;
    end
    chk("t6_rr_reset", 64'(in_ready), 64'(3'b001));
    step(1);
    in_valid = '0;
    wait_idle(40);

    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
